// File: rtl/sevenseg_scan_n.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_n
//   Time-multiplexed driver for an NDIGITS common-anode 7-segment display.
//   Each digit slot lasts 2**DIV_LOG2 clocks. The digit codes are captured at
//   slot boundaries. The outputs provide hex decode, a dash glyph, blanking,
//   optional leading-zero suppression and PWM brightness control.
//
// Parameters
//   NDIGITS   digits scanned (1..16), digit 0 is the rightmost
//   DIV_LOG2  log2 of clocks per digit slot
//   DUTY_W    brightness width, DUTY_W <= DIV_LOG2
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   d_all       digit i code at [7*i+6:7*i] = {blank, dp, dash, data[3:0]}
//   brightness  0 = 1/2**DUTY_W duty, all ones = full duty
//   lz_en       1 = suppress leading zeros
//   segs_n      active-low segments {g,f,e,d,c,b,a}
//   dp_n        active-low decimal point
//   an_n        active-low anode enables (one-hot low or all ones)
// -----------------------------------------------------------------------------
module sevenseg_scan_n #(
  parameter int NDIGITS  = 8,
  parameter int DIV_LOG2 = 17,
  parameter int DUTY_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7*NDIGITS-1:0]   d_all,
  input  logic [DUTY_W-1:0]      brightness,
  input  logic                   lz_en,
  output logic [6:0]             segs_n,
  output logic                   dp_n,
  output logic [NDIGITS-1:0]     an_n
);

  localparam int          IDX_W      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [6:0]  CODE_BLANK = 7'b1000000;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;
  localparam logic [6:0]  SEG_DASH   = 7'b0111111;

  logic [DIV_LOG2-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7*NDIGITS-1:0] snap_q, snap_d;
  logic [6:0]           segs_n_q, segs_n_d;
  logic                 dp_n_q, dp_n_d;
  logic [NDIGITS-1:0]   an_n_q, an_n_d;

  // Combinational helpers for the currently scanned digit.
  logic [6:0]           cur_code;
  logic                 cur_supp;
  logic [NDIGITS-1:0]   supp;
  logic                 zero_run;
  logic [DUTY_W-1:0]    duty;
  logic                 pwm_on;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  // Slot counter, digit index and snapshot advance together at the slot end.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (cnt_q == '1) begin
      idx_d  = (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
      snap_d = d_all;
    end
  end

  // Leading-zero suppression: a digit is dark while it and every digit above it
  // hold the plain zero code. Digit 0 always shows.
  always_comb begin
    supp     = '0;
    zero_run = lz_en;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (snap_q[7*k +: 7] == 7'b0000000);
      supp[k]  = zero_run;
    end
    supp[0] = 1'b0;
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur_code = CODE_BLANK;
    cur_supp = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code = snap_q[7*i +: 7];
        cur_supp = supp[i];
      end
    end
  end

  assign duty   = cnt_q[DIV_LOG2-1 -: DUTY_W];
  assign pwm_on = (duty <= brightness);

  // Output decode, priority blank > suppressed > dash > hex. The anode follows
  // PWM even for a blanked digit.
  always_comb begin
    segs_n_d = SEG_OFF;
    dp_n_d   = 1'b1;
    an_n_d   = '1;
    if (pwm_on) begin
      an_n_d = ~(NDIGITS'(1) << idx_q);
      if (!(cur_code[6] || cur_supp)) begin
        segs_n_d = cur_code[4] ? SEG_DASH : hex_decode(cur_code[3:0]);
        dp_n_d   = ~cur_code[5];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      // NOTE: the snapshot is a register bank, not a RAM, and is reset so the first slot shows blank.
      snap_q   <= {NDIGITS{CODE_BLANK}};
      segs_n_q <= SEG_OFF;
      dp_n_q   <= 1'b1;
      an_n_q   <= '1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      segs_n_q <= segs_n_d;
      dp_n_q   <= dp_n_d;
      an_n_q   <= an_n_d;
    end
  end

  assign segs_n = segs_n_q;
  assign dp_n   = dp_n_q;
  assign an_n   = an_n_q;

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_n
//   Directed bench for sevenseg_scan_n with NDIGITS=4, DIV_LOG2=4, DUTY_W=2.
//   The bench keeps itself aligned to 16-cycle slots from reset release.
//   Outputs are sampled on the falling edge. After rising edge k of a slot,
//   the outputs show that slot's state with cnt = k-1.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_n;

  localparam int NDIGITS  = 4;
  localparam int DIV_LOG2 = 4;
  localparam int DUTY_W   = 2;
  localparam int SLOT     = 16;

  logic                 clk;
  logic                 rst;
  logic [7*NDIGITS-1:0] d_all;
  logic [DUTY_W-1:0]    brightness;
  logic                 lz_en;
  logic [6:0]           segs_n;
  logic                 dp_n;
  logic [NDIGITS-1:0]   an_n;

  int n_cmp = 0;
  int n_bad = 0;

  sevenseg_scan_n #(
    .NDIGITS (NDIGITS),
    .DIV_LOG2(DIV_LOG2),
    .DUTY_W  (DUTY_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d_all     (d_all),
    .brightness(brightness),
    .lz_en     (lz_en),
    .segs_n    (segs_n),
    .dp_n      (dp_n),
    .an_n      (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hand-written glyph table for hex digits.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] code(input logic blank, input logic dp,
                                      input logic dash, input logic [3:0] d);
    code = {blank, dp, dash, d};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic skip(input int n);
    repeat (n) step();
  endtask

  // Check one full slot of digit idx. The digit is lit while cnt[3:2] <= br.
  task automatic check_slot(input string tag, input int idx, input logic [6:0] seg,
                            input logic dpn, input int br);
    logic             on;
    logic [NDIGITS-1:0] exp_an;
    for (int k = 0; k < SLOT; k++) begin
      step();
      on     = ((k / 4) <= br);
      exp_an = on ? ~(NDIGITS'(1) << idx) : '1;
      check($sformatf("%s.an[%0d]", tag, k), 32'(an_n), 32'(exp_an));
      check($sformatf("%s.seg[%0d]", tag, k), 32'(segs_n), 32'(on ? seg : 7'h7F));
      check($sformatf("%s.dp[%0d]", tag, k), 32'(dp_n), 32'(on ? dpn : 1'b1));
    end
  endtask

  task automatic check_frame(input string tag, input logic [27:0] segs,
                             input logic [3:0] dpn, input int br);
    for (int i = 0; i < NDIGITS; i++)
      check_slot($sformatf("%s.d%0d", tag, i), i, segs[7*i +: 7], dpn[i], br);
  endtask

  // Load new codes at a frame start; a full frame later every slot shows them.
  task automatic load(input logic [27:0] d);
    d_all = d;
    skip(NDIGITS * SLOT);
  endtask

  logic [6:0] z;
  logic       dp;

  initial begin
    z          = hex7(4'h0);
    rst        = 1'b1;
    d_all      = '0;
    brightness = 2'd3;
    lz_en      = 1'b0;
    #1;
    check("por.seg", 32'(segs_n), 32'h7F);
    check("por.dp", 32'(dp_n), 32'h1);
    check("por.an", 32'(an_n), 32'hF);

    // Scan: digits 3..0 = 3,2,1,0. The first slot after reset is blank.
    d_all = {code(0,0,0,4'h3), code(0,0,0,4'h2), code(0,0,0,4'h1), code(0,0,0,4'h0)};
    @(negedge clk);
    rst = 1'b0;
    check_slot("first_blank", 0, 7'h7F, 1'b1, 3);
    check_slot("scan", 1, hex7(4'h1), 1'b1, 3);
    check_slot("scan", 2, hex7(4'h2), 1'b1, 3);
    check_slot("scan", 3, hex7(4'h3), 1'b1, 3);
    check_slot("wrap", 0, hex7(4'h0), 1'b1, 3);
    skip(3 * SLOT);  // back to a frame start

    // Decode sweep on digit 0; odd values also light the dp.
    for (int v = 0; v < 16; v++) begin
      dp = 1'(v);
      load({z, z, z, code(0, dp, 0, 4'(v))} & {21'h0, 7'h7F});
      check_frame($sformatf("hex%0h", v), {z, z, z, hex7(4'(v))}, {3'b111, ~dp}, 3);
    end
    load({21'h0, code(0,0,1,4'h5)});
    check_frame("dash", {z, z, z, 7'b0111111}, 4'b1111, 3);
    load({21'h0, code(0,1,1,4'h8)});
    check_frame("dash_dp", {z, z, z, 7'b0111111}, 4'b1110, 3);
    load({21'h0, code(1,1,0,4'h8)});
    check_frame("blank_dp", {z, z, z, 7'h7F}, 4'b1111, 3);

    // PWM on an "8." in digit 0.
    load({21'h0, code(0,1,0,4'h8)});
    brightness = 2'd0;
    check_frame("pwm0", {z, z, z, 7'b0000000}, 4'b1110, 0);
    brightness = 2'd2;
    check_frame("pwm2", {z, z, z, 7'b0000000}, 4'b1110, 2);
    brightness = 2'd3;
    check_frame("pwm3", {z, z, z, 7'b0000000}, 4'b1110, 3);

    // Leading-zero suppression.
    lz_en = 1'b1;
    load({code(0,0,0,4'h0), code(0,0,0,4'h0), code(0,0,0,4'h7), code(0,0,0,4'h0)});
    check_frame("lz_0070", {7'h7F, 7'h7F, hex7(4'h7), z}, 4'b1111, 3);
    load('0);
    check_frame("lz_zero", {7'h7F, 7'h7F, 7'h7F, z}, 4'b1111, 3);
    load({code(0,0,1,4'h0), 21'h0});
    check_frame("lz_dash", {7'b0111111, z, z, z}, 4'b1111, 3);
    load({code(0,1,0,4'h0), 21'h0});
    check_frame("lz_dp", {z, z, z, z}, 4'b0111, 3);
    load({code(1,0,0,4'h0), 21'h0});
    check_frame("lz_blank", {7'h7F, z, z, z}, 4'b1111, 3);

    // Snapshot: digit 1 changes from 5 to 9 five cycles into its slot.
    lz_en = 1'b0;
    load({14'h0, code(0,0,0,4'h5), 7'h0});
    check_slot("snap", 0, z, 1'b1, 3);
    for (int k = 0; k < SLOT; k++) begin
      if (k == 5) d_all = {14'h0, code(0,0,0,4'h9), 7'h0};
      step();
      check($sformatf("snap_hold.an[%0d]", k), 32'(an_n), 32'h D);
      check($sformatf("snap_hold.seg[%0d]", k), 32'(segs_n), 32'(hex7(4'h5)));
    end
    check_slot("snap", 2, z, 1'b1, 3);
    check_slot("snap", 3, z, 1'b1, 3);
    check_slot("snap_new", 0, z, 1'b1, 3);
    check_slot("snap_new", 1, hex7(4'h9), 1'b1, 3);

    // Asynchronous reset mid-scan, away from a clock edge.
    skip(3);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid.seg", 32'(segs_n), 32'h7F);
    check("rst_mid.dp", 32'(dp_n), 32'h1);
    check("rst_mid.an", 32'(an_n), 32'hF);
    d_all = {14'h0, code(0,0,0,4'h9), code(0,1,0,4'h8)};
    @(negedge clk);
    rst = 1'b0;
    check_slot("rst_blank", 0, 7'h7F, 1'b1, 3);
    check_slot("rst_after", 1, hex7(4'h9), 1'b1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
